memory_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-port 256x8 Memory block between two requesters, e.g. instruction fetch (port A) and data access (port B).
- Each port uses a valid/ready request handshake and a valid/ready response handshake.
- At most one memory access is issued per cycle.
- Each port has a one-entry response buffer, so a slow consumer stalls only its own port.

---
 rtl/memory_arbiter.sv | 171 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: two-port round-robin arbiter in front of a single-port
// 256x8 memory. Each port has a valid/ready request channel and a one-entry
// valid/ready response buffer, so a stalled consumer blocks only its own port.

// Per-port one-entry response buffer.
module memory_arbiter_rsp #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept_i,    // request granted this cycle
    input  logic              rready_i,    // consumer drains the buffer
    input  logic              we_i,        // granted access is a write
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o
);
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;

    // Next state: a new accept overrides a drain; a drain alone empties the
    // buffer but keeps the data. Writes answer with the written value so the
    // response is write-first independent of the memory's read timing.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (accept_i) begin
            rvalid_d = 1'b1;
            rdata_d  = we_i ? wdata_i : mem_rdata_i;
        end else if (rready_i) begin
            rvalid_d = 1'b0;
        end
    end

    // Buffer registers; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
endmodule

module memory_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    // port A
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rvalid,
    input  logic              a_rready,
    output logic [DATA_W-1:0] a_rdata,
    // port B
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rvalid,
    input  logic              b_rready,
    output logic [DATA_W-1:0] b_rdata,
    // memory
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int NUM_PORTS = 2;
    localparam int PA = 0;
    localparam int PB = 1;

    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    req_t [NUM_PORTS-1:0]             req;
    logic [NUM_PORTS-1:0]             req_vld;
    logic [NUM_PORTS-1:0]             rsp_rdy;
    logic [NUM_PORTS-1:0]             rsp_vld;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rsp_data;
    logic [NUM_PORTS-1:0]             elig;
    logic [NUM_PORTS-1:0]             gnt;
    port_e                            last_grant_q, last_grant_d;

    // Gather the scalar port pins into per-port arrays.
    assign req[PA]     = '{we: a_we, addr: a_addr, wdata: a_wdata};
    assign req[PB]     = '{we: b_we, addr: b_addr, wdata: b_wdata};
    assign req_vld     = {b_valid, a_valid};
    assign rsp_rdy     = {b_rready, a_rready};

    // A port may be granted only if its response slot is free or draining now.
    // Reset masks every request so no access reaches memory during reset.
    assign elig = req_vld & (~rsp_vld | rsp_rdy) & {NUM_PORTS{rst_n}};

    // Round-robin pick: a tie goes to the port that did not win last time;
    // otherwise elig is already zero or one-hot.
    always_comb begin
        gnt = elig;
        if (&elig)
            gnt = (last_grant_q == PORT_B) ? 2'b01 : 2'b10;
    end

    assign a_ready = gnt[PA];
    assign b_ready = gnt[PB];

    // Drive memory from the granted port; park everything at zero when idle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[PA]) begin
            mem_we    = req[PA].we;
            mem_addr  = req[PA].addr;
            mem_wdata = req[PA].wdata;
        end else if (gnt[PB]) begin
            mem_we    = req[PB].we;
            mem_addr  = req[PB].addr;
            mem_wdata = req[PB].wdata;
        end
    end

    // Round-robin pointer moves only when something was granted.
    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt[PA]) last_grant_d = PORT_A;
        if (gnt[PB]) last_grant_d = PORT_B;
    end

    // Pointer register; reset to B so A wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) last_grant_q <= PORT_B;
        else        last_grant_q <= last_grant_d;
    end

    // One response buffer per port.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rsp
        memory_arbiter_rsp #(.DATA_W(DATA_W)) u_rsp (
            .clk         (clk),
            .rst_n       (rst_n),
            .accept_i    (gnt[i]),
            .rready_i    (rsp_rdy[i]),
            .we_i        (req[i].we),
            .wdata_i     (req[i].wdata),
            .mem_rdata_i (mem_rdata),
            .rvalid_o    (rsp_vld[i]),
            .rdata_o     (rsp_data[i])
        );
    end

    assign a_rvalid = rsp_vld[PA];
    assign a_rdata  = rsp_data[PA];
    assign b_rvalid = rsp_vld[PB];
    assign b_rdata  = rsp_data[PB];
endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: directed scenarios followed by random traffic.
// A reference model predicts grants/memory drive each cycle and queues the
// expected response data; a monitor checks responses against the queues.
module tb_memory_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 0, a_we = 0, a_rready = 1;
    logic [7:0] a_addr = 0, a_wdata = 0;
    logic       b_valid = 0, b_we = 0, b_rready = 1;
    logic [7:0] b_addr = 0, b_wdata = 0;
    logic       a_ready, a_rvalid, b_ready, b_rvalid, mem_we;
    logic [7:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    memory_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rready(a_rready), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rready(b_rready), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // The memory device itself: combinational read, write at posedge.
    logic [7:0] mem [256];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    // Reference state: memory contents, pending-response flags, tie-break turn.
    logic [7:0] mmem [256];
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit         pa = 0, pb = 0;
    bit         last_b = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 8'h00;
            mmem[i] = 8'h00;
        end
    end

    // Model: predicts this cycle's grant and memory drive, then advances.
    initial begin : model
        bit ea, eb, ga, gb;
        logic [7:0] xa, xw;
        forever begin
            @(negedge clk); #1;
            ea = rst_n && a_valid && (!pa || a_rready);
            eb = rst_n && b_valid && (!pb || b_rready);
            ga = ea && (!eb || last_b);
            gb = eb && !ga;
            xa = ga ? a_addr : (gb ? b_addr : 8'h00);
            xw = (ga && a_we) ? a_wdata : ((gb && b_we) ? b_wdata : 8'h00);
            chk("a_ready", a_ready, ga);
            chk("b_ready", b_ready, gb);
            chk("mem_we", mem_we, (ga && a_we) || (gb && b_we));
            chk("mem_addr", mem_addr, xa);
            if (mem_we) chk("mem_wdata", mem_wdata, xw);
            if (!rst_n) begin
                qa.delete(); qb.delete();
                pa = 0; pb = 0; last_b = 1;
            end else begin
                if (ga) begin
                    qa.push_back(a_we ? a_wdata : mmem[a_addr]);
                    if (a_we) mmem[a_addr] = a_wdata;
                    pa = 1; last_b = 0;
                end else if (a_rready) pa = 0;
                if (gb) begin
                    qb.push_back(b_we ? b_wdata : mmem[b_addr]);
                    if (b_we) mmem[b_addr] = b_wdata;
                    pb = 1; last_b = 1;
                end else if (b_rready) pb = 0;
            end
        end
    end

    // Monitor: response valid must track the queue; data must match its head.
    initial begin : monitor
        forever begin
            @(negedge clk);
            chk("a_rvalid", a_rvalid, qa.size() != 0);
            if (a_rvalid && qa.size() != 0) begin
                chk("a_rdata", a_rdata, qa[0]);
                if (a_rready) void'(qa.pop_front());
            end
            chk("b_rvalid", b_rvalid, qb.size() != 0);
            if (b_rvalid && qb.size() != 0) begin
                chk("b_rdata", b_rdata, qb[0]);
                if (b_rready) void'(qb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_a(input bit v, input bit we, input logic [7:0] ad, input logic [7:0] wd);
        a_valid = v; a_we = we; a_addr = ad; a_wdata = wd;
    endtask

    task automatic set_b(input bit v, input bit we, input logic [7:0] ad, input logic [7:0] wd);
        b_valid = v; b_we = we; b_addr = ad; b_wdata = wd;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] exp5 [3];
        bit hs_a, hs_b;
        exp5[0] = 8'd10; exp5[1] = 8'd11; exp5[2] = 8'd0;

        // 1: reset, A write then read of addr 0
        repeat (3) step();
        rst_n = 1;
        set_a(1, 1, 8'd0, 8'd10);
        @(negedge clk); chk("t1_a_ready", a_ready, 1);
        step();
        set_a(1, 0, 8'd0, 8'd0);
        @(negedge clk); chk("t1_a_rdata", a_rdata, 8'd10);
        step();
        set_a(0, 0, 8'd0, 8'd0);
        step();

        // 2: continuous contention, grants alternate from A after reset
        rst_n = 0; step(); rst_n = 1;
        set_a(1, 1, 8'd1, 8'd11);
        set_b(1, 0, 8'd2, 8'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_a_rr", a_ready, (i % 2) == 0);
            chk("t2_b_rr", b_ready, (i % 2) == 1);
            step();
        end
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        step();

        // 3: same-address write (A) then read (B)
        set_a(1, 1, 8'd5, 8'h55);
        set_b(1, 0, 8'd5, 8'h00);
        step();
        set_a(0, 0, 0, 0);
        step();
        set_b(0, 0, 0, 0);
        @(negedge clk);
        chk("t3_b_rvalid", b_rvalid, 1);
        chk("t3_b_rdata", b_rdata, 8'h55);
        step();

        // 4: B stalled on its response while A keeps getting grants
        a_rready = 1; b_rready = 0;
        set_a(1, 0, 8'd0, 0);
        set_b(1, 0, 8'd5, 0);
        @(negedge clk); chk("t4_a_first", a_ready, 1); step();
        @(negedge clk); chk("t4_b_acc", b_ready, 1); step();
        set_b(1, 0, 8'd1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_b_blocked", b_ready, 0);
            chk("t4_a_served", a_ready, 1);
            chk("t4_b_hold", b_rdata, 8'h55);
            step();
        end
        b_rready = 1;
        @(negedge clk); chk("t4_b_resume", b_ready, 1); step();
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        step();

        // 5: uncontended back-to-back A reads
        for (int k = 0; k < 3; k++) begin
            set_a(1, 0, 8'(k), 0);
            @(negedge clk);
            chk("t5_a_ready", a_ready, 1);
            if (k > 0) chk("t5_a_rdata", a_rdata, exp5[k-1]);
            step();
        end
        set_a(0, 0, 0, 0);
        @(negedge clk);
        chk("t5_a_rvalid", a_rvalid, 1);
        chk("t5_a_rdata_last", a_rdata, exp5[2]);
        step();

        // 6: reset with a pending A response
        a_rready = 0;
        set_a(1, 0, 8'd1, 0);
        step();
        set_a(1, 1, 8'd3, 8'h33);
        set_b(1, 1, 8'd4, 8'h44);
        rst_n = 0;
        step();
        @(negedge clk);
        chk("t6_a_rvalid", a_rvalid, 0);
        chk("t6_a_rdata", a_rdata, 0);
        chk("t6_mem_we", mem_we, 0);
        chk("t6_ready", {a_ready, b_ready}, 0);
        step();
        rst_n = 1; a_rready = 1;
        @(negedge clk);
        chk("t6_tie_a", a_ready, 1);
        chk("t6_tie_b", b_ready, 0);
        step();

        // random traffic with rare resets; requests held until accepted
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hs_a = a_valid && a_ready;
            hs_b = b_valid && b_ready;
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 299) != 0);
            if (!a_valid || hs_a)
                set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      8'($urandom_range(0, 7)), 8'($urandom));
            if (!b_valid || hs_b)
                set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      8'($urandom_range(0, 7)), 8'($urandom));
            a_rready = ($urandom_range(0, 3) != 0);
            b_rready = ($urandom_range(0, 3) != 0);
        end
        rst_n = 1;
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        a_rready = 1; b_rready = 1;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
